// File: rtl/debounced_edge_detector.sv
// Debounced level follower with registered rise/fall pulses
// and a saturating count of accepted rising changes.
module debounced_edge_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_i,
    input  logic             clr_cnt_i,
    output logic             stable_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_PEND,
        S_HIGH,
        S_FALL_PEND
    } state_t;

    // Last debounce count before a pending change is accepted.
    localparam logic [7:0]       DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_sync_d;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_db_cnt;
    logic [7:0]       w_db_cnt_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_edge_cnt;

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= d_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync_d = r_sync2;

    // FSM state and debounce counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_LOW;
            r_db_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
        end
    end

    // Next-state, debounce count and pulse decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        unique case (r_state)
            S_LOW: begin
                if (w_sync_d) begin
                    w_state_nxt  = S_RISE_PEND;
                    w_db_cnt_nxt = 8'd1;
                end else begin
                    w_db_cnt_nxt = 8'd0;
                end
            end
            S_RISE_PEND: begin
                if (!w_sync_d) begin
                    w_state_nxt  = S_LOW;
                    w_db_cnt_nxt = 8'd0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = S_HIGH;
                    w_db_cnt_nxt = 8'd0;
                    w_rise_nxt   = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 8'd1;
                end
            end
            S_HIGH: begin
                if (!w_sync_d) begin
                    w_state_nxt  = S_FALL_PEND;
                    w_db_cnt_nxt = 8'd1;
                end else begin
                    w_db_cnt_nxt = 8'd0;
                end
            end
            S_FALL_PEND: begin
                if (w_sync_d) begin
                    w_state_nxt  = S_HIGH;
                    w_db_cnt_nxt = 8'd0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = S_LOW;
                    w_db_cnt_nxt = 8'd0;
                    w_fall_nxt   = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = S_LOW;
                w_db_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Registered level and one-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            if (w_rise_nxt) begin
                r_stable <= 1'b1;
            end else if (w_fall_nxt) begin
                r_stable <= 1'b0;
            end
        end
    end

    // Saturating rise counter; clear wins over a same-cycle rise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_edge_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_edge_cnt <= '0;
        end else if (w_rise_nxt && (r_edge_cnt != CNT_MAX)) begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    assign stable_o   = r_stable;
    assign rise_o     = r_rise;
    assign fall_o     = r_fall;
    assign edge_cnt_o = r_edge_cnt;

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Directed bench for debounced_edge_detector
// (DEBOUNCE_CYCLES=4, CNT_W=2 to reach saturation quickly).
module tb_debounced_edge_detector;

    logic       clk;
    logic       reset;
    logic       d_i;
    logic       clr_cnt_i;
    logic       stable_o;
    logic       rise_o;
    logic       fall_o;
    logic [1:0] edge_cnt_o;

    int n_cmp;
    int n_err;

    debounced_edge_detector #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_i       (d_i),
        .clr_cnt_i (clr_cnt_i),
        .stable_o  (stable_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .edge_cnt_o(edge_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset with d_i high, then qualify d_i as a normal rise.
    task automatic test_reset;
        reset     = 1'b0;
        d_i       = 1'b1;
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        tick();
        n_cmp++;
        if ({stable_o, rise_o, fall_o, edge_cnt_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outs got %b want 00000",
                     {stable_o, rise_o, fall_o, edge_cnt_o});
        end
        reset = 1'b1;
        for (int j = 0; j < 9; j++) begin
            tick();
            n_cmp++;
            if (rise_o !== (j == 5) || fall_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_rise j=%0d rise=%b fall=%b want %b 0",
                         j, rise_o, fall_o, (j == 5));
            end
            n_cmp++;
            if (stable_o !== (j >= 5)) begin
                n_err++;
                $display("FAIL reset_stable j=%0d got %b want %b",
                         j, stable_o, (j >= 5));
            end
        end
        n_cmp++;
        if (edge_cnt_o !== 2'd1) begin
            n_err++;
            $display("FAIL reset_cnt got %0d want 1", edge_cnt_o);
        end
    endtask

    // Clean fall from HIGH, same latency as rise.
    task automatic test_fall;
        d_i = 1'b0;
        for (int j = 0; j < 9; j++) begin
            tick();
            n_cmp++;
            if (fall_o !== (j == 5) || rise_o !== 1'b0) begin
                n_err++;
                $display("FAIL fall_pulse j=%0d fall=%b rise=%b want %b 0",
                         j, fall_o, rise_o, (j == 5));
            end
            n_cmp++;
            if (stable_o !== (j < 5)) begin
                n_err++;
                $display("FAIL fall_stable j=%0d got %b want %b",
                         j, stable_o, (j < 5));
            end
        end
    endtask

    // Two-cycle high glitch from LOW must be rejected.
    task automatic test_short_pulse;
        d_i = 1'b1;
        tick();
        tick();
        d_i = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_cmp++;
            if ({stable_o, rise_o, fall_o} !== 3'b000) begin
                n_err++;
                $display("FAIL glitch j=%0d s/r/f=%b want 000",
                         j, {stable_o, rise_o, fall_o});
            end
        end
        n_cmp++;
        if (edge_cnt_o !== 2'd1) begin
            n_err++;
            $display("FAIL glitch_cnt got %0d want 1", edge_cnt_o);
        end
    endtask

    // Clean rise, hold 10 cycles, clean fall.
    task automatic test_clean;
        int n_rise;
        int n_fall;
        n_rise = 0;
        n_fall = 0;
        d_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            n_rise += int'(rise_o);
            n_fall += int'(fall_o);
            n_cmp++;
            if (rise_o !== (j == 5)) begin
                n_err++;
                $display("FAIL clean_rise j=%0d got %b want %b",
                         j, rise_o, (j == 5));
            end
        end
        n_cmp++;
        if (stable_o !== 1'b1 || edge_cnt_o !== 2'd2) begin
            n_err++;
            $display("FAIL clean_high stable=%b cnt=%0d want 1 2",
                     stable_o, edge_cnt_o);
        end
        d_i = 1'b0;
        for (int j = 0; j < 9; j++) begin
            tick();
            n_rise += int'(rise_o);
            n_fall += int'(fall_o);
            n_cmp++;
            if (fall_o !== (j == 5) || stable_o !== (j < 5)) begin
                n_err++;
                $display("FAIL clean_fall j=%0d fall=%b stable=%b",
                         j, fall_o, stable_o);
            end
        end
        n_cmp++;
        if (n_rise != 1 || n_fall != 1) begin
            n_err++;
            $display("FAIL clean_count rises=%0d falls=%0d want 1 1",
                     n_rise, n_fall);
        end
    endtask

    // d_i = 1,0,1,1,1,1 then held: rise only after 4 clean highs.
    task automatic test_toggle;
        logic [5:0] pat;
        pat = 6'b111101;
        for (int j = 0; j < 12; j++) begin
            d_i = (j < 6) ? pat[j] : 1'b1;
            tick();
            n_cmp++;
            if (rise_o !== (j == 7) || stable_o !== (j >= 7)) begin
                n_err++;
                $display("FAIL toggle j=%0d rise=%b stable=%b want %b %b",
                         j, rise_o, stable_o, (j == 7), (j >= 7));
            end
        end
        n_cmp++;
        if (edge_cnt_o !== 2'd3) begin
            n_err++;
            $display("FAIL toggle_cnt got %0d want 3", edge_cnt_o);
        end
        d_i = 1'b0;
        for (int j = 0; j < 8; j++) tick();
    endtask

    // Clear, five rises saturating at 3, clear racing a rise.
    task automatic test_counter;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        n_cmp++;
        if (edge_cnt_o !== 2'd0 || stable_o !== 1'b0) begin
            n_err++;
            $display("FAIL cnt_clear cnt=%0d stable=%b want 0 0",
                     edge_cnt_o, stable_o);
        end
        for (int k = 0; k < 5; k++) begin
            d_i = 1'b1;
            for (int j = 0; j < 6; j++) tick();
            n_cmp++;
            if (rise_o !== 1'b1 || edge_cnt_o !== exp_cnt[k]) begin
                n_err++;
                $display("FAIL cnt_sat k=%0d rise=%b cnt=%0d want 1 %0d",
                         k, rise_o, edge_cnt_o, exp_cnt[k]);
            end
            d_i = 1'b0;
            for (int j = 0; j < 8; j++) tick();
        end
        d_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            clr_cnt_i = (j == 5);
            tick();
        end
        clr_cnt_i = 1'b0;
        n_cmp++;
        if (rise_o !== 1'b1 || stable_o !== 1'b1 || edge_cnt_o !== 2'd0) begin
            n_err++;
            $display("FAIL cnt_clr_rise rise=%b stable=%b cnt=%0d want 1 1 0",
                     rise_o, stable_o, edge_cnt_o);
        end
        d_i = 1'b0;
        for (int j = 0; j < 8; j++) tick();
    endtask

    // Reset while RISE_PEND with db_cnt=2 drops the pending change.
    task automatic test_reset_pending;
        d_i = 1'b1;
        for (int j = 0; j < 6; j++) tick();
        d_i = 1'b0;
        for (int j = 0; j < 8; j++) tick();
        n_cmp++;
        if (edge_cnt_o !== 2'd1) begin
            n_err++;
            $display("FAIL pend_pre_cnt got %0d want 1", edge_cnt_o);
        end
        d_i = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        reset = 1'b0;
        d_i   = 1'b0;
        tick();
        reset = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_cmp++;
            if ({stable_o, rise_o, fall_o} !== 3'b000) begin
                n_err++;
                $display("FAIL pend_abandon j=%0d s/r/f=%b want 000",
                         j, {stable_o, rise_o, fall_o});
            end
        end
        n_cmp++;
        if (edge_cnt_o !== 2'd0) begin
            n_err++;
            $display("FAIL pend_cnt got %0d want 0", edge_cnt_o);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        d_i       = 1'b0;
        clr_cnt_i = 1'b0;
        test_reset();
        test_fall();
        test_short_pulse();
        test_clean();
        test_toggle();
        test_counter();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounced_edge_detector.md
DEBOUNCED_EDGE_DETECTOR -- requirements
Module: debounced_edge_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of consecutive equal synchronized samples needed to accept a level change; the legal range is 2..255.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the rising-edge counter.
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-low reset: reset==0 at a clk rising edge resets the block.
REQ-005 Port d_i  input  1  SHALL be the raw, asynchronous, possibly bouncing level input.
REQ-006 Port clr_cnt_i  input  1  SHALL be a synchronous clear for edge_cnt_o.
REQ-007 Port stable_o  output  1  SHALL be the debounced level.
REQ-008 Port rise_o  output  1  SHALL be a one-cycle pulse on each accepted 0->1 change.
REQ-009 Port fall_o  output  1  SHALL be a one-cycle pulse on each accepted 1->0 change.
REQ-010 Port edge_cnt_o  output  CNT_W  SHALL be a saturating count of rise_o pulses.

Function
REQ-011 d_i SHALL pass through a 2-flop synchronizer; its output (sync_d) SHALL be the only source of d_i information for the FSM.
REQ-012 The FSM SHALL have exactly four states: LOW, RISE_PEND, HIGH, FALL_PEND.
REQ-013 In LOW with sync_d==1, the FSM SHALL go to RISE_PEND with db_cnt=1; otherwise it SHALL stay in LOW.
REQ-014 In RISE_PEND with sync_d==0, the FSM SHALL return to LOW with no pulse and db_cnt=0.
REQ-015 In RISE_PEND with sync_d==1 and db_cnt<DEBOUNCE_CYCLES-1, db_cnt SHALL increment.
REQ-016 In RISE_PEND with sync_d==1 and db_cnt==DEBOUNCE_CYCLES-1, the FSM SHALL go to HIGH, set stable_o=1, and assert rise_o for exactly the following cycle.
REQ-017 HIGH and FALL_PEND SHALL mirror REQ-013..REQ-016 with sync_d polarity inverted, going to LOW with stable_o=0 and asserting fall_o.
REQ-018 rise_o, fall_o, and stable_o SHALL be registered, with no combinational path from any input.
REQ-019 rise_o and fall_o SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-020 Latency: if d_i rises before clk edge E and stays high, rise_o SHALL be high during the cycle after edge E+DEBOUNCE_CYCLES+1 (edge E+5 for default parameters); the same latency SHALL apply to fall_o.
REQ-021 A sync_d pulse shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no stable_o change.
REQ-022 edge_cnt_o SHALL increment by 1 on each edge where the FSM enters HIGH, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 clr_cnt_i==1 SHALL set edge_cnt_o to 0 at the next edge; clear SHALL take priority over a simultaneous increment (result 0).
REQ-024 clr_cnt_i SHALL NOT affect FSM state, db_cnt, stable_o, rise_o, or fall_o.

Reset
REQ-025 When reset==0 at a clk edge, the synchronizer flops, db_cnt, stable_o, rise_o, fall_o, and edge_cnt_o SHALL all be 0, and the FSM SHALL be in LOW.
REQ-026 Reset SHALL override clr_cnt_i and all FSM transitions.
REQ-027 Reset asserted while in RISE_PEND or FALL_PEND SHALL abandon the pending change with no pulse.
REQ-028 If d_i is held 1 through reset, then after reset release the block SHALL qualify it as a normal rising change: rise_o pulses with the REQ-020 latency, measured from the first edge with reset==1.

Verification
REQ-029 Scenario: reset=0 for 2 cycles with d_i=1, then release -> all outputs 0 during reset; rise_o pulses once, DEBOUNCE_CYCLES+1 edges after the first edge with reset==1; edge_cnt_o=1.
REQ-030 Scenario: from LOW, d_i high for 2 cycles (default DEBOUNCE_CYCLES=4) then low -> no rise_o, stable_o stays 0, edge_cnt_o unchanged.
REQ-031 Scenario: clean d_i 0->1, held 10 cycles, then 1->0 -> exactly one rise_o and one fall_o, each at REQ-020 latency; stable_o high between them.
REQ-032 Scenario: d_i toggles 1,0,1,1,1,1 on successive edges from LOW -> one rise_o only after 4 consecutive synchronized highs.
REQ-033 Scenario: CNT_W=2 with 5 qualified rising edges -> edge_cnt_o reads 1,2,3,3,3; clr_cnt_i in the same cycle as a rise -> edge_cnt_o=0.
REQ-034 Scenario: reset=0 asserted while in RISE_PEND with db_cnt=2 -> no rise_o, state LOW, edge_cnt_o=0.
